// File: rtl/accum_cpu_core.sv
// ============================================================================
//  Module   : accum_cpu_core
//  Brief    : Multi-cycle accumulator computer with FSM, ALU, memory,
//             program-load/debug ports and a saturating retired counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module accum_cpu_core #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [DATA_W-1:0] ac_out,
   output logic              e_out,
   output logic [ADDR_W-1:0] pc_out,
   output logic              busy,
   output logic              halted,
   output logic [CNT_W-1:0]  retired
);

   localparam logic [2:0] c_S_IDLE = 3'd0;
   localparam logic [2:0] c_S_T0   = 3'd1;
   localparam logic [2:0] c_S_T1   = 3'd2;
   localparam logic [2:0] c_S_T2   = 3'd3;
   localparam logic [2:0] c_S_T3   = 3'd4;
   localparam logic [2:0] c_S_T4   = 3'd5;
   localparam logic [2:0] c_S_HALT = 3'd6;

   localparam logic [3:0] c_OP_LDA = 4'h1;
   localparam logic [3:0] c_OP_STA = 4'h2;
   localparam logic [3:0] c_OP_ADD = 4'h3;
   localparam logic [3:0] c_OP_SUB = 4'h4;
   localparam logic [3:0] c_OP_AND = 4'h5;
   localparam logic [3:0] c_OP_OR  = 4'h6;
   localparam logic [3:0] c_OP_XOR = 4'h7;
   localparam logic [3:0] c_OP_JMP = 4'h8;
   localparam logic [3:0] c_OP_JZ  = 4'h9;
   localparam logic [3:0] c_OP_JC  = 4'hA;
   localparam logic [3:0] c_OP_INC = 4'hB;
   localparam logic [3:0] c_OP_CLA = 4'hC;
   localparam logic [3:0] c_OP_CMA = 4'hD;
   localparam logic [3:0] c_OP_CIL = 4'hE;
   localparam logic [3:0] c_OP_HLT = 4'hF;

   logic [2:0]        r_state;
   logic [2:0]        w_next;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_ar;
   logic [DATA_W-1:0] r_ir;
   logic [DATA_W-1:0] r_dr;
   logic [DATA_W-1:0] r_ac;
   logic              r_e;
   logic [CNT_W-1:0]  r_retired;
   logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

   logic [3:0]        w_op;
   logic [ADDR_W-1:0] w_addr;
   logic              w_mem_op;
   logic              w_is_sta;
   logic              w_accept;
   logic              w_prog_wr;
   logic              w_sta_wr;
   logic              w_retire;
   logic              w_busy;
   logic              w_halted;
   logic              w_mem_we;
   logic              w_unused_ir;

   assign w_op        = r_ir[DATA_W-1 -: 4];
   assign w_addr      = r_ir[ADDR_W-1:0];
   assign w_mem_op    = (w_op >= c_OP_LDA) && (w_op <= c_OP_XOR);
   assign w_is_sta    = (w_op == c_OP_STA);
   assign w_unused_ir = ^r_ir;

   always_ff @(posedge clock) begin
      if (reset) r_state <= c_S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_S_IDLE, c_S_HALT: if (start) w_next = c_S_T0;
         c_S_T0: w_next = c_S_T1;
         c_S_T1: w_next = c_S_T2;
         c_S_T2: begin
            if (w_op == c_OP_HLT) w_next = c_S_HALT;
            else if (w_mem_op)    w_next = c_S_T3;
            else                  w_next = c_S_T0;
         end
         c_S_T3: w_next = w_is_sta ? c_S_T0 : c_S_T4;
         c_S_T4: w_next = c_S_T0;
         default: w_next = c_S_IDLE;
      endcase
   end

   always_comb begin
      w_busy    = 1'b1;
      w_halted  = 1'b0;
      w_accept  = 1'b0;
      w_prog_wr = 1'b0;
      w_sta_wr  = 1'b0;
      w_retire  = 1'b0;
      case (r_state)
         c_S_IDLE, c_S_HALT: begin
            w_busy    = 1'b0;
            w_halted  = (r_state == c_S_HALT);
            w_accept  = start;
            w_prog_wr = prog_we;
         end
         c_S_T2: w_retire = !w_mem_op;
         c_S_T3: begin
            w_sta_wr = w_is_sta;
            w_retire = w_is_sta;
         end
         c_S_T4: w_retire = 1'b1;
         default: ;
      endcase
   end

   // Reset suppresses any write in the same cycle so memory survives an abort.
   assign w_mem_we = !reset && (w_prog_wr || w_sta_wr);

   always_ff @(posedge clock) begin
      if (w_mem_we) begin
         if (w_sta_wr) r_mem[r_ar]     <= r_ac;
         else          r_mem[prog_addr] <= prog_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_pc      <= '0;
         r_ar      <= '0;
         r_ir      <= '0;
         r_dr      <= '0;
         r_ac      <= '0;
         r_e       <= 1'b0;
         r_retired <= '0;
      end else begin
         case (r_state)
            c_S_IDLE, c_S_HALT: begin
               if (w_accept) begin
                  r_pc      <= '0;
                  r_ac      <= '0;
                  r_e       <= 1'b0;
                  r_retired <= '0;
               end
            end
            c_S_T0: r_ar <= r_pc;
            c_S_T1: begin
               r_ir <= r_mem[r_ar];
               r_pc <= r_pc + ADDR_W'(1);
            end
            c_S_T2: begin
               r_ar <= w_addr;
               case (w_op)
                  c_OP_JMP: r_pc <= w_addr;
                  c_OP_JZ:  if (r_ac == '0) r_pc <= w_addr;
                  c_OP_JC:  if (r_e) r_pc <= w_addr;
                  c_OP_INC: {r_e, r_ac} <= {1'b0, r_ac} + (DATA_W+1)'(1);
                  c_OP_CLA: begin
                     r_ac <= '0;
                     r_e  <= 1'b0;
                  end
                  c_OP_CMA: r_ac <= ~r_ac;
                  c_OP_CIL: {r_e, r_ac} <= {r_ac, r_e};
                  default: ;
               endcase
            end
            c_S_T3: if (!w_is_sta) r_dr <= r_mem[r_ar];
            c_S_T4: begin
               case (w_op)
                  c_OP_LDA: r_ac <= r_dr;
                  c_OP_ADD: {r_e, r_ac} <= {1'b0, r_ac} + {1'b0, r_dr};
                  c_OP_SUB: {r_e, r_ac} <= {1'b0, r_ac} + {1'b0, ~r_dr} + (DATA_W+1)'(1);
                  c_OP_AND: r_ac <= r_ac & r_dr;
                  c_OP_OR:  r_ac <= r_ac | r_dr;
                  c_OP_XOR: r_ac <= r_ac ^ r_dr;
                  default: ;
               endcase
            end
            default: ;
         endcase
         if (w_retire && (r_retired != {CNT_W{1'b1}}))
            r_retired <= r_retired + CNT_W'(1);
      end
   end

   assign dbg_data = r_mem[dbg_addr];
   assign ac_out   = r_ac;
   assign e_out    = r_e;
   assign pc_out   = r_pc;
   assign busy     = w_busy;
   assign halted   = w_halted;
   assign retired  = r_retired;

endmodule

`default_nettype wire
